// File: rtl/cla_sub_pipe.sv
// Pipelined carry-lookahead subtractor: diff = a - b - b_in, one 4-bit CLA slice
// resolved per stage, valid/ready handshake with bubble-collapsing flow control.
module cla_sub_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         b_out,
  output logic         ovf
);

  localparam int STAGES = N / 4;

  if ((N % 4) != 0 || N < 4) begin : g_bad_width
    $error("cla_sub_pipe: N must be a multiple of 4 and at least 4");
  end

  // Returns {carry_out, sum[3:0]} with all four carries resolved in parallel.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, p ^ {c3, c2, c1, ci}};
  endfunction

  // Per-stage registers
  logic         v_r    [STAGES];
  logic [N-1:0] res_r  [STAGES];
  logic         c_r    [STAGES];
  logic [N-1:0] a_r    [STAGES];
  logic [N-1:0] nb_r   [STAGES];
  logic         amsb_r [STAGES];
  logic         bmsb_r [STAGES];
  logic         b_out_r, ovf_r;

  // Stage inputs: slot 0 is fed by the ports, slot k by stage k-1 registers
  logic         src_v   [STAGES];
  logic [N-1:0] src_res [STAGES];
  logic         src_c   [STAGES];
  logic [N-1:0] src_a   [STAGES];
  logic [N-1:0] src_nb  [STAGES];
  logic         src_am  [STAGES];
  logic         src_bm  [STAGES];

  logic [4:0]   sl      [STAGES];
  logic [N-1:0] nxt_res [STAGES];
  logic [N-1:0] nxt_a   [STAGES];
  logic [N-1:0] nxt_nb  [STAGES];
  logic [STAGES:0] adv;

  always_comb begin
    adv = '0;
    adv[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[STAGES-1-i] = !v_r[STAGES-1-i] || adv[STAGES-i];
    end
  end

  always_comb begin
    src_v[0]   = in_valid;
    src_res[0] = '0;
    src_c[0]   = ~b_in;
    src_a[0]   = a;
    src_nb[0]  = ~b;
    src_am[0]  = a[N-1];
    src_bm[0]  = b[N-1];
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v[k]   = v_r[k-1];
      src_res[k] = res_r[k-1];
      src_c[k]   = c_r[k-1];
      src_a[k]   = a_r[k-1];
      src_nb[k]  = nb_r[k-1];
      src_am[k]  = amsb_r[k-1];
      src_bm[k]  = bmsb_r[k-1];
    end
  end

  // Consumed operand bits are zeroed so only a[N-1:4k+4] / ~b[N-1:4k+4] travel on.
  always_comb begin
    sl      = '{default: '0};
    nxt_res = '{default: '0};
    nxt_a   = '{default: '0};
    nxt_nb  = '{default: '0};
    for (int unsigned k = 0; k < STAGES; k++) begin
      sl[k]      = cla4(src_a[k][4*k +: 4], src_nb[k][4*k +: 4], src_c[k]);
      nxt_res[k] = src_res[k] | (N'(sl[k][3:0]) << (4*k));
      nxt_a[k]   = src_a[k]  & ({N{1'b1}} << (4*k + 4));
      nxt_nb[k]  = src_nb[k] & ({N{1'b1}} << (4*k + 4));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_r[k]    <= 1'b0;
        res_r[k]  <= '0;
        c_r[k]    <= 1'b0;
        a_r[k]    <= '0;
        nb_r[k]   <= '0;
        amsb_r[k] <= 1'b0;
        bmsb_r[k] <= 1'b0;
      end
      b_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_r[k]    <= src_v[k];
          res_r[k]  <= nxt_res[k];
          c_r[k]    <= sl[k][4];
          a_r[k]    <= nxt_a[k];
          nb_r[k]   <= nxt_nb[k];
          amsb_r[k] <= src_am[k];
          bmsb_r[k] <= src_bm[k];
        end
      end
      // Borrow and overflow are registered with the last stage so reset leaves them 0.
      if (adv[STAGES-1]) begin
        b_out_r <= ~sl[STAGES-1][4];
        ovf_r   <= (src_am[STAGES-1] != src_bm[STAGES-1]) &&
                   (nxt_res[STAGES-1][N-1] != src_am[STAGES-1]);
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_r[STAGES-1];
  assign diff      = res_r[STAGES-1];
  assign b_out     = b_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Scoreboard bench for cla_sub_pipe: directed vectors on an 8-bit instance
// plus a 16-bit instance latency/borrow check.
module tb_cla_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b, diff;
  logic        b_in, b_out, ovf;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, diff16;
  logic        b_in16, b_out16, ovf16;

  cla_sub_pipe #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out), .ovf(ovf)
  );

  cla_sub_pipe #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .b_in(b_in16), .out_valid(out_valid16), .out_ready(out_ready16),
    .diff(diff16), .b_out(b_out16), .ovf(ovf16)
  );

  typedef struct packed { logic [7:0] d; logic bo; logic ov; } exp8_t;
  typedef struct packed { logic [15:0] d; logic bo; logic ov; } exp16_t;

  exp8_t  q8[$];
  exp16_t q16[$];
  int tests = 0;
  int fails = 0;
  bit stop_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per accepted output
  always @(negedge clk) begin
    exp8_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out8: got diff %0h expected no output", diff);
      end else begin
        e = q8.pop_front();
        chk("diff8", {24'd0, diff}, {24'd0, e.d});
        chk("bout8", {31'd0, b_out}, {31'd0, e.bo});
        chk("ovf8",  {31'd0, ovf},   {31'd0, e.ov});
      end
    end
  end

  always @(negedge clk) begin
    exp16_t e;
    if (rst_n && out_valid16 && out_ready16) begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out16: got diff %0h expected no output", diff16);
      end else begin
        e = q16.pop_front();
        chk("diff16", {16'd0, diff16}, {16'd0, e.d});
        chk("bout16", {31'd0, b_out16}, {31'd0, e.bo});
        chk("ovf16",  {31'd0, ovf16},   {31'd0, e.ov});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that transfers.
  task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       input logic [7:0] ed, input logic ebo, input logic eov);
    bit ok;
    exp8_t e;
    ok = 1'b0;
    a = ta; b = tb; b_in = tbin; in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = ed; e.bo = ebo; e.ov = eov;
        q8.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send8_timeout: got in_ready 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic drain8();
    for (int i = 0; i < 200 && q8.size() != 0; i++) @(posedge clk);
    chk("drain8_empty", q8.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rbin;
    logic [8:0] full;
    exp16_t     e16;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; b_in16 = 1'b0; out_ready16 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_diff",      {24'd0, diff}, 0);
    chk("rst_b_out",     {31'd0, b_out}, 0);
    chk("rst_ovf",       {31'd0, ovf}, 0);
    chk("rst_in_ready",  {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtract with latency check
    send8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); chk("lat8_early", {31'd0, out_valid}, 0);
    @(negedge clk); chk("lat8_t2",    {31'd0, out_valid}, 1);
    @(posedge clk); #1;

    // Borrow, borrow-in and signed overflow vectors, back to back
    send8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    send8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    send8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    send8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain8();

    // Backpressure: two accepted, third refused while head is held stable
    out_ready = 1'b0;
    send8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);
    send8(8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0);
    a = 8'h03; b = 8'h05; b_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  {31'd0, in_ready}, 0);
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_diff_hold", {24'd0, diff}, 32'h05);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain8();

    // Streaming with random backpressure against a reference subtraction
    stop_ready = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
          full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
          send8(ra, rb, rbin, full[7:0], full[8], (ra[7] != rb[7]) && (full[7] != ra[7]));
        end
        in_valid = 1'b0;
        stop_ready = 1'b1;
      end
      begin
        while (!stop_ready) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain8();

    // Reset with two operations in flight
    out_ready = 1'b0;
    send8(8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0);
    send8(8'h40, 8'h10, 1'b0, 8'h30, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 0);
    chk("rst_async_diff",  {24'd0, diff}, 0);
    q8.delete();
    q16.delete();
    out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 0);
    end
    @(posedge clk); #1;
    send8(8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); chk("rst_lat_early", {31'd0, out_valid}, 0);
    @(negedge clk); chk("rst_lat_t2",    {31'd0, out_valid}, 1);
    drain8();

    // 16-bit instance: four-stage latency and full-width borrow
    a16 = 16'h0000; b16 = 16'h0001; b_in16 = 1'b0; in_valid16 = 1'b1;
    @(negedge clk);
    chk("in_ready16", {31'd0, in_ready16}, 1);
    e16.d = 16'hFFFF; e16.bo = 1'b1; e16.ov = 1'b0;
    q16.push_back(e16);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat16_early", {31'd0, out_valid16}, 0);
    end
    @(negedge clk); chk("lat16_t4", {31'd0, out_valid16}, 1);
    repeat (3) @(posedge clk);
    chk("drain16_empty", q16.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
